// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: shared widths, FSM states and buffer entry layout for rom_burst_reader
package rom_reader_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, FIN = 2'b11} state_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } buf_entry_t;
endpackage

// File: rtl/rom_out_buf.sv
// rom_out_buf: 2-entry synchronous FIFO, push and pop may coincide even when full
module rom_out_buf #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp    <= wp ^ push;
      rp    <= rp ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  assign head = mem[rp];
endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: walks a ROM address range into a valid/ready stream; ROM_READER_CHECKSUM_EN adds checksum output
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);
  localparam logic [ADDR_W:0] LEN_ONE = 1;
  state_t st, st_nx;
  logic [ADDR_W:0] rem;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0] cnt, cnt_nx;
  logic p1, p2, p2_nx, push, pop, issue, accept;
  // p1: rom_addr was just issued and not yet sampled; p2: rom_data holds an uncaptured word for d_addr.
  // A held rom_addr is re-read every cycle, so an uncaptured word survives as long as no newer issue follows.
  always_comb begin
    accept = st == IDLE && start;
    pop    = out_valid & out_ready;
    push   = p2 & (cnt < 2'(BUF_DEPTH) | pop);
    cnt_nx = cnt + 2'(push) - 2'(pop);
    p2_nx  = (p2 & ~push) | p1;
    issue  = st == RUN && rem != '0 && !(p2_nx && cnt_nx == 2'(BUF_DEPTH));
    st_nx  = accept ? (length == '0 ? FIN : length == LEN_ONE ? DRAIN : RUN)
           : st == RUN ? (issue && rem == LEN_ONE ? DRAIN : RUN)
           : st == DRAIN ? (!p1 && !p2_nx && cnt_nx == '0 ? FIN : DRAIN)
           : st == FIN ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= IDLE;
      rem      <= '0;
      rom_addr <= '0;
      d_addr   <= '0;
      p1       <= 1'b0;
      p2       <= 1'b0;
    end else begin
      st <= st_nx;
      p2 <= p2_nx;
      p1 <= accept ? length != '0 : issue;
      if (p1) d_addr <= rom_addr;
      if (accept && length != '0) begin
        rom_addr <= base_addr;
        rem      <= length - LEN_ONE;
      end else if (issue) begin
        rom_addr <= rom_addr + 1'b1;
        rem      <= rem - LEN_ONE;
      end
    end
  rom_out_buf #(.W(ADDR_W + DATA_W)) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  ({d_addr, rom_data}),
    .head ({out_addr, out_data}),
    .count(cnt)
  );
  assign out_valid = cnt != '0;
  assign busy      = st != IDLE;
  assign done      = st == FIN;
`ifdef ROM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) checksum <= '0;
    else checksum <= accept ? 8'h00 : pop ? checksum + 8'(out_data) : checksum;
`endif
endmodule
